// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline.
// Produces per-register stall/flush controls and the PC redirect from a
// prioritised set of hazard events, and counts cycles with the PC held.
module pipe_hazard_ctrl #(
    parameter int unsigned MULTI_CYCLES = 4,
    parameter int unsigned REG_AW       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [1:0]        id_rs_used,
    input  logic              ex_multi,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              imem_ready,
    input  logic              mem_req,
    input  logic              dmem_ready,
    output logic              pc_stall,
    output logic              pc_redirect,
    output logic [31:0]       pc_target,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_stall,
    output logic              id_ex_flush,
    output logic              ex_mem_stall,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic              ex_busy,
    output logic [31:0]       stall_cycles
);

    localparam int unsigned      CNT_W    = $clog2(MULTI_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_CYCLES - 2);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MULTI = 2'd1,
        MWAIT = 2'd2
    } state_t;

    state_t           state, state_nx;
    state_t           saved, saved_nx;
    state_t           eff;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             dwait;
    logic             multi_stall;
    logic             load_use;

    // State register, multi-cycle counter and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            saved        <= RUN;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_nx;
            saved <= saved_nx;
            cnt   <= cnt_nx;
            if (pc_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

    // Prioritised hazard evaluation: control outputs and next state
    always_comb begin
        pc_stall     = 1'b0;
        pc_redirect  = 1'b0;
        pc_target    = '0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        ex_busy      = 1'b0;
        state_nx     = state;
        saved_nx     = saved;
        cnt_nx       = cnt;

        // Once the dmem wait clears, MWAIT behaves exactly as the state it
        // interrupted, so the release cycle resumes that state's work directly.
        eff         = (state == MWAIT) ? saved : state;
        dwait       = mem_req && !dmem_ready;
        multi_stall = ((eff == RUN) && ex_multi) || ((eff == MULTI) && (cnt != '0));
        load_use    = ex_mem_read && (ex_rd != '0) &&
                      ((id_rs_used[0] && (id_rs1 == ex_rd)) ||
                       (id_rs_used[1] && (id_rs2 == ex_rd)));

        if (rst) begin
            state_nx = RUN;
            saved_nx = RUN;
            cnt_nx   = '0;
        end else if (dwait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
            state_nx     = MWAIT;
            saved_nx     = eff;
        end else if (multi_stall) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
            ex_busy      = 1'b1;
            state_nx     = MULTI;
            cnt_nx       = (eff == RUN) ? CNT_LOAD : cnt - CNT_W'(1);
        end else begin
            state_nx = RUN;
            if (branch_taken) begin
                pc_redirect = 1'b1;
                pc_target   = branch_target;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end else if (!imem_ready) begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MC = 4;
    localparam int unsigned AW = 5;

    // Bit positions inside the packed control vector
    localparam int PCS = 9, PCR = 8, IIS = 7, IIF = 6, IES = 5,
                   IEF = 4, EMS = 3, EMF = 2, MWF = 1, BSY = 0;

    logic          clk;
    logic          rst;
    logic          ex_mem_read;
    logic [AW-1:0] ex_rd, id_rs1, id_rs2;
    logic [1:0]    id_rs_used;
    logic          ex_multi, branch_taken;
    logic [31:0]   branch_target;
    logic          imem_ready, mem_req, dmem_ready;
    logic          pc_stall, pc_redirect;
    logic [31:0]   pc_target;
    logic          if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic          ex_mem_stall, ex_mem_flush, mem_wb_flush, ex_busy;
    logic [31:0]   stall_cycles;
    logic [9:0]    got_ctrl;
    logic [9:0]    obs;

    int unsigned   n_checks;
    int unsigned   n_errors;

    // Reference model state
    bit            m_inop;
    int unsigned   m_done;
    logic [31:0]   m_stall;

    pipe_hazard_ctrl #(
        .MULTI_CYCLES(MC),
        .REG_AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs_used(id_rs_used),
        .ex_multi(ex_multi), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_ready(imem_ready),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush), .ex_busy(ex_busy),
        .stall_cycles(stall_cycles)
    );

    assign got_ctrl = {pc_stall, pc_redirect, if_id_stall, if_id_flush, id_ex_stall,
                       id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_flush, ex_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; ex_mem_read = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
        id_rs_used = 2'b00; ex_multi = 1'b0; branch_taken = 1'b0;
        branch_target = '0; imem_ready = 1'b1; mem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model
    task automatic step();
        logic        dw, busy, lu;
        logic [9:0]  e;
        logic [31:0] et;
        @(negedge clk);
        e  = '0;
        et = '0;
        dw   = mem_req && !dmem_ready;
        busy = !dw && (m_inop ? (m_done < MC - 1) : ex_multi);
        lu   = ex_mem_read && (ex_rd != 0) &&
               ((id_rs_used[0] && id_rs1 == ex_rd) || (id_rs_used[1] && id_rs2 == ex_rd));
        if (rst) begin
            e = '0;
        end else if (dw) begin
            e[PCS] = 1; e[IIS] = 1; e[IES] = 1; e[EMS] = 1; e[MWF] = 1;
        end else if (busy) begin
            e[PCS] = 1; e[IIS] = 1; e[IES] = 1; e[EMF] = 1; e[BSY] = 1;
        end else if (branch_taken) begin
            e[PCR] = 1; e[IIF] = 1; e[IEF] = 1; et = branch_target;
        end else if (lu) begin
            e[PCS] = 1; e[IIS] = 1; e[IEF] = 1;
        end else if (!imem_ready) begin
            e[PCS] = 1; e[IIF] = 1;
        end
        obs = got_ctrl;
        check_val("ctrl", {22'd0, got_ctrl}, {22'd0, e});
        check_val("pc_target", pc_target, et);
        check_val("stall_cycles", stall_cycles, m_stall);
        @(posedge clk);
        if (rst) begin
            m_inop  = 0;
            m_done  = 0;
            m_stall = '0;
        end else begin
            if (e[PCS] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (!dw) begin
                if (m_inop) begin
                    if (m_done < MC - 1) m_done++;
                    else m_inop = 0;
                end else if (ex_multi) begin
                    m_inop = 1;
                    m_done = 1;
                end
            end
        end
        #1;
    endtask

    initial begin
        int busy_cnt;
        n_checks = 0;
        n_errors = 0;
        m_inop   = 0;
        m_done   = 0;
        m_stall  = '0;
        obs      = '0;
        idle_inputs();

        // Reset: everything zero
        rst = 1'b1;
        step();
        step();
        check_val("reset_ctrl", {22'd0, obs}, 32'd0);
        rst = 1'b0;
        step();

        // Load-use on rs1, then same pattern with x0 as destination
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs_used = 2'b01;
        step();
        check_val("loaduse_stall", {31'd0, obs[PCS] & obs[IIS] & obs[IEF]}, 32'd1);
        ex_rd = 5'd0; id_rs1 = 5'd0;
        step();
        check_val("loaduse_x0", {22'd0, obs}, 32'd0);
        idle_inputs();

        // Branch beats load-use and imem wait in the same cycle
        branch_taken = 1'b1; branch_target = 32'h100;
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs_used = 2'b01;
        imem_ready = 1'b0;
        step();
        check_val("branch_pc_stall", {31'd0, obs[PCS]}, 32'd0);
        idle_inputs();

        // Multi-cycle op held: exactly MC-1 busy cycles
        ex_multi = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            busy_cnt += int'(obs[BSY]);
        end
        check_val("multi_busy", busy_cnt, MC - 1);
        ex_multi = 1'b0;
        step();

        // DWAIT in the middle of a multi-cycle op freezes its progress
        ex_multi = 1'b1;
        step();
        step();
        mem_req = 1'b1; dmem_ready = 1'b0;
        step();
        step();
        dmem_ready = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            busy_cnt += int'(obs[BSY]);
        end
        check_val("dwait_resume_busy", busy_cnt, 1);
        idle_inputs();
        step();

        // Reset during a multi-cycle op
        ex_multi = 1'b1;
        step();
        rst = 1'b1;
        step();
        check_val("rst_mid_multi", {22'd0, obs}, 32'd0);
        rst = 1'b0; ex_multi = 1'b0;
        step();
        check_val("after_rst_nostall", {22'd0, obs}, 32'd0);
        check_val("after_rst_cnt", stall_cycles, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(63) == 0);
            ex_mem_read   = ($urandom_range(2) == 0);
            ex_rd         = AW'($urandom_range(3));
            id_rs1        = AW'($urandom_range(3));
            id_rs2        = AW'($urandom_range(3));
            id_rs_used    = 2'($urandom_range(3));
            ex_multi      = ($urandom_range(7) == 0);
            branch_taken  = ($urandom_range(5) == 0);
            branch_target = $urandom;
            imem_ready    = ($urandom_range(5) != 0);
            mem_req       = ($urandom_range(2) == 0);
            dmem_ready    = ($urandom_range(1) == 0);
            step();
        end

        // Saturation of the stall counter
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        force dut.stall_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles;
        m_stall = 32'hFFFF_FFFE;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        imem_ready = 1'b1;
        step();
        check_val("stall_saturate", stall_cycles, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
